// File: rtl/ds1302_slave_model_if.sv
// Local-side port of the DS1302 target: preload strobe in, committed-write report out.
// Latency: none (wires only).
// Backpressure: none; the preload strobe is accepted every cycle.
interface ds1302_slave_model_if;
    logic       iLdEn;
    logic [5:0] iLdAddr;
    logic [7:0] iLdData;
    logic       oWrStb;
    logic [5:0] oWrAddr;
    logic [7:0] oWrData;
    logic       oBusy;

    modport master (
        output iLdEn, iLdAddr, iLdData,
        input  oWrStb, oWrAddr, oWrData, oBusy
    );

    modport slave (
        input  iLdEn, iLdAddr, iLdData,
        output oWrStb, oWrAddr, oWrData, oBusy
    );
endinterface

// File: rtl/ds1302_slave_model.sv
// DS1302-compatible 3-wire target: 8 clock bytes + RAM bank, serial read/write, local preload.
// Latency: read bit driven SYNC_STG+1 CLOCKs after raw SCLK fall; write reported 2 CLOCKs after last rise is seen.
// Backpressure: none; the master paces everything through SCLK and CE.
module ds1302_slave_model #(
    parameter int SYNC_STG  = 2,
    parameter int RAM_DEPTH = 31
) (
    input  logic CLOCK,
    input  logic RST_n,
    input  logic RTC_NRST,
    input  logic RTC_SCLK,
    inout  wire  RTC_DATA,
    ds1302_slave_model_if.slave lp
);
    typedef enum logic [2:0] {IDLE, CMD, WDATA, COMMIT, RDATA, IGNORE} state_t;

    localparam logic [5:0] RAM_LIM = 6'(RAM_DEPTH);

    state_t state_q, state_d;

    logic [SYNC_STG-1:0] ce_sync, sclk_sync, data_sync;
    logic ce_s, sclk_s, data_s;
    logic ce_prev, sclk_prev;
    logic sclk_rise, sclk_fall;

    logic [3:0] bit_cnt;
    logic [7:0] shift_q;
    logic [7:0] shift_in;
    logic       tgt_bank;
    logic [4:0] tgt_addr;
    logic [7:0] rd_sh;
    logic [7:0] rd_val;
    logic       drive_en;
    logic       out_bit;
    logic       cmd_bad;
    logic       wr_allow;
    logic       wr_commit;

    logic [7:0] clk_reg [8];
    logic [7:0] ram     [RAM_DEPTH];

    logic       wr_stb;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;

    assign ce_s      = ce_sync[SYNC_STG-1];
    assign sclk_s    = sclk_sync[SYNC_STG-1];
    assign data_s    = data_sync[SYNC_STG-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;

    // Incoming serial bit lands in the MSB; after 8 rises the byte is LSB-first aligned.
    assign shift_in = {data_s, shift_q[7:1]};

    // Burst (addr 31), missing b7, or RAM beyond the populated depth are not served.
    assign cmd_bad = ~shift_in[7] | (shift_in[5:1] == 5'd31) |
                     (shift_in[6] & ({1'b0, shift_in[5:1]} >= RAM_LIM));

    // Write-protect blocks everything except the control register itself.
    assign wr_allow = ~clk_reg[7][7] | (~tgt_bank & (tgt_addr == 5'd7));

    assign RTC_DATA   = drive_en ? out_bit : 1'bz;
    assign lp.oBusy   = (state_q != IDLE);
    assign lp.oWrStb  = wr_stb;
    assign lp.oWrAddr = wr_addr;
    assign lp.oWrData = wr_data;

    // Bring CE, SCLK and IO into the CLOCK domain.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            ce_sync   <= '0;
            sclk_sync <= '0;
            data_sync <= '0;
        end else begin
            ce_sync   <= {ce_sync[SYNC_STG-2:0], RTC_NRST};
            sclk_sync <= {sclk_sync[SYNC_STG-2:0], RTC_SCLK};
            data_sync <= {data_sync[SYNC_STG-2:0], RTC_DATA};
        end
    end

    // Byte addressed by the just-completed command; unpopulated locations read zero.
    always_comb begin
        rd_val = 8'h00;
        if (shift_in[6]) begin
            if ({1'b0, shift_in[5:1]} < RAM_LIM) begin
                rd_val = ram[shift_in[5:1]];
            end
        end else if (shift_in[5:4] == 2'b00) begin
            rd_val = clk_reg[shift_in[3:1]];
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and commit decision; CE low aborts from anywhere.
    always_comb begin
        state_d   = state_q;
        wr_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (ce_s && !ce_prev) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (sclk_rise && bit_cnt == 4'd7) begin
                    if (cmd_bad) begin
                        state_d = IGNORE;
                    end else if (shift_in[0]) begin
                        state_d = RDATA;
                    end else begin
                        state_d = WDATA;
                    end
                end
            end
            WDATA: begin
                if (sclk_rise && bit_cnt == 4'd7) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                wr_commit = wr_allow;
                state_d   = IGNORE;
            end
            RDATA: begin
                if (sclk_fall && bit_cnt == 4'd8) begin
                    state_d = IGNORE;
                end
            end
            IGNORE: begin
                state_d = IGNORE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!ce_s) begin
            state_d   = IDLE;
            wr_commit = 1'b0;
        end
    end

    // Serial datapath: bit counting, shift-in, read shift-out and IO drive enable.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            ce_prev   <= 1'b0;
            sclk_prev <= 1'b0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            tgt_bank  <= 1'b0;
            tgt_addr  <= '0;
            rd_sh     <= '0;
            drive_en  <= 1'b0;
            out_bit   <= 1'b0;
        end else begin
            ce_prev   <= ce_s;
            sclk_prev <= sclk_s;
            case (state_q)
                IDLE: begin
                    bit_cnt <= '0;
                end
                CMD: begin
                    if (sclk_rise) begin
                        shift_q <= shift_in;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt  <= '0;
                            tgt_bank <= shift_in[6];
                            tgt_addr <= shift_in[5:1];
                            rd_sh    <= rd_val;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        shift_q <= shift_in;
                        bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
                    end
                end
                RDATA: begin
                    if (sclk_fall) begin
                        if (bit_cnt == 4'd8) begin
                            drive_en <= 1'b0;
                        end else begin
                            drive_en <= 1'b1;
                            out_bit  <= rd_sh[0];
                            rd_sh    <= {1'b0, rd_sh[7:1]};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
            if (!ce_s) begin
                drive_en <= 1'b0;
            end
        end
    end

    // Register file: local preload first so a same-address serial commit overrides it.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < 8; i++) begin
                clk_reg[i] <= '0;
            end
            for (int i = 0; i < RAM_DEPTH; i++) begin
                ram[i] <= '0;
            end
        end else begin
            if (lp.iLdEn) begin
                if (!lp.iLdAddr[5] && lp.iLdAddr[4:3] == 2'b00) begin
                    clk_reg[lp.iLdAddr[2:0]] <= lp.iLdData;
                end else if (lp.iLdAddr[5] && ({1'b0, lp.iLdAddr[4:0]} < RAM_LIM)) begin
                    ram[lp.iLdAddr[4:0]] <= lp.iLdData;
                end
            end
            if (wr_commit) begin
                if (!tgt_bank && tgt_addr[4:3] == 2'b00) begin
                    clk_reg[tgt_addr[2:0]] <= shift_q;
                end else if (tgt_bank && ({1'b0, tgt_addr} < RAM_LIM)) begin
                    ram[tgt_addr] <= shift_q;
                end
            end
        end
    end

    // Committed-write report: one-cycle strobe, address/data held until the next commit.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_stb <= wr_commit;
            if (wr_commit) begin
                wr_addr <= {tgt_bank, tgt_addr};
                wr_data <= shift_q;
            end
        end
    end
endmodule
